// File: rtl/pmp_pkg.sv
// Shared PMP definitions: cfg byte layout, address-match modes, privilege levels, checker FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pmp_pkg;

    // Bit positions inside one pmpcfg byte
    localparam int unsigned PMP_CFG_R     = 0;
    localparam int unsigned PMP_CFG_W     = 1;
    localparam int unsigned PMP_CFG_X     = 2;
    localparam int unsigned PMP_CFG_A_LSB = 3;
    localparam int unsigned PMP_CFG_A_MSB = 4;
    localparam int unsigned PMP_CFG_L     = 7;

    typedef enum logic [1:0] {
        PMP_OFF   = 2'd0,
        PMP_TOR   = 2'd1,
        PMP_NA4   = 2'd2,
        PMP_NAPOT = 2'd3
    } pmp_addr_mode_e;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_e addr_mode;
        logic           x;
        logic           w;
        logic           r;
    } pmp_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_RESP
    } pmp_state_e;

    // Unpack one raw pmpcfg byte into named fields
    function automatic pmp_cfg_t pmp_decode_cfg(input logic [7:0] b);
        pmp_cfg_t c;
        c.r         = b[PMP_CFG_R];
        c.w         = b[PMP_CFG_W];
        c.x         = b[PMP_CFG_X];
        c.addr_mode = pmp_addr_mode_e'(b[PMP_CFG_A_MSB:PMP_CFG_A_LSB]);
        c.reserved  = b[6:5];
        c.locked    = b[PMP_CFG_L];
        return c;
    endfunction

    // Permission decision for a matching entry. W without R is reserved and grants no write.
    function automatic logic pmp_allow(input logic [2:0] access, input pmp_cfg_t cfg,
                                       input logic [1:0] priv);
        logic [2:0] perm;
        perm = {cfg.x, cfg.w & cfg.r, cfg.r};
        if (priv == PRIV_LVL_M && !cfg.locked) begin
            return 1'b1;
        end
        return ((access & ~perm) == 3'b000);
    endfunction

endpackage

// File: rtl/pmp_entry.sv
// Single PMP entry address matcher (OFF / TOR / NA4 / NAPOT).
// Latency: purely combinational.
// Backpressure: none; no handshake.
module pmp_entry
    import pmp_pkg::*;
#(
    parameter int unsigned PLEN    = 56,
    parameter int unsigned PMP_LEN = 54
) (
    input  logic [PLEN-1:0]    addr_i,
    input  logic [PMP_LEN-1:0] conf_addr_i,
    input  logic [PMP_LEN-1:0] conf_addr_prev_i,
    input  pmp_addr_mode_e     conf_addr_mode_i,
    output logic               match_o
);

    logic [PMP_LEN-1:0] addr_word;
    logic [PMP_LEN-1:0] napot_mask;

    assign addr_word  = addr_i[PLEN-1:2];
    // Trailing ones of pmpaddr select the region size; the mask keeps only the base bits above them
    assign napot_mask = ~(conf_addr_i ^ (conf_addr_i + PMP_LEN'(1)));

    // Region match for the selected addressing mode
    always_comb begin
        match_o = 1'b0;
        unique case (conf_addr_mode_i)
            PMP_TOR:   match_o = (addr_i >= {conf_addr_prev_i, 2'b00}) &&
                                 (addr_i <  {conf_addr_i, 2'b00});
            PMP_NA4:   match_o = (addr_word == conf_addr_i);
            PMP_NAPOT: match_o = ((addr_word & napot_mask) == (conf_addr_i & napot_mask));
            default:   match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: walks the entry table one entry per cycle through one shared matcher.
// Latency: hit on entry k -> response k+2 cycles after accept; no hit -> NR_ENTRIES+1 cycles.
// Backpressure: one request in flight; response held until rsp_ready_i, req_ready_o low meanwhile.
module pmp_seq_checker
    import pmp_pkg::*;
#(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16,
    localparam int unsigned IDX_W     = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [PLEN-1:0]              addr_i,
    input  logic [2:0]                   access_i,
    input  logic [1:0]                   priv_lvl_i,
    input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
    input  logic [NR_ENTRIES*8-1:0]      conf_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic                         rsp_allow_o,
    output logic                         rsp_hit_o,
    output logic [IDX_W-1:0]             rsp_idx_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

    pmp_state_e         state_q;
    logic [IDX_W-1:0]   scan_idx_q;
    logic [PLEN-1:0]    addr_q;
    logic [2:0]         access_q;
    logic [1:0]         priv_q;
    logic               rsp_valid_q;
    logic               rsp_allow_q;
    logic               rsp_hit_q;
    logic [IDX_W-1:0]   rsp_idx_q;

    logic [PMP_LEN-1:0] conf_addr_arr [NR_ENTRIES];
    pmp_cfg_t           cfg_arr       [NR_ENTRIES];

    logic [PMP_LEN-1:0] cur_conf_addr;
    logic [PMP_LEN-1:0] prev_conf_addr;
    pmp_cfg_t           cur_cfg;
    logic               entry_match;
    logic               hit_allow_d;
    logic               miss_allow_d;
    logic               cfg_unused;

    // CSR arrays are read live; the CSR file holds them stable while a check is in flight
    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_unpack
        assign conf_addr_arr[i] = conf_addr_i[i*PMP_LEN +: PMP_LEN];
        assign cfg_arr[i]       = pmp_decode_cfg(conf_i[i*8 +: 8]);
    end

    // Operand mux: current entry and its TOR lower bound (entry 0 is bounded by address 0)
    always_comb begin
        cur_conf_addr  = conf_addr_arr[scan_idx_q];
        cur_cfg        = cfg_arr[scan_idx_q];
        prev_conf_addr = '0;
        if (scan_idx_q != '0) begin
            prev_conf_addr = conf_addr_arr[scan_idx_q - IDX_W'(1)];
        end
    end

    assign cfg_unused = ^cur_cfg.reserved;

    pmp_entry #(
        .PLEN    (PLEN),
        .PMP_LEN (PMP_LEN)
    ) u_pmp_entry (
        .addr_i           (addr_q),
        .conf_addr_i      (cur_conf_addr),
        .conf_addr_prev_i (prev_conf_addr),
        .conf_addr_mode_i (cur_cfg.addr_mode),
        .match_o          (entry_match)
    );

    assign hit_allow_d  = pmp_allow(access_q, cur_cfg, priv_q);
    assign miss_allow_d = (priv_q == PRIV_LVL_M);

    assign req_ready_o  = (state_q == ST_IDLE) && !flush_i;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_allow_o  = rsp_allow_q;
    assign rsp_hit_o    = rsp_hit_q;
    assign rsp_idx_o    = rsp_idx_q;

    // Control FSM: accept, scan entries in index order, hold the registered response until taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            scan_idx_q  <= '0;
            addr_q      <= '0;
            access_q    <= '0;
            priv_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_allow_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        addr_q     <= addr_i;
                        access_q   <= access_i;
                        priv_q     <= priv_lvl_i;
                        scan_idx_q <= '0;
                        state_q    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else if (entry_match) begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b1;
                        rsp_idx_q   <= scan_idx_q;
                        rsp_allow_q <= hit_allow_d;
                        state_q     <= ST_RESP;
                    end else if (scan_idx_q == LAST_IDX) begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b0;
                        rsp_idx_q   <= '0;
                        rsp_allow_q <= miss_allow_d;
                        state_q     <= ST_RESP;
                    end else begin
                        scan_idx_q <= scan_idx_q + IDX_W'(1);
                    end
                end
                ST_RESP: begin
                    if (flush_i || rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Self-checking bench for pmp_seq_checker: vector table plus hand sequences, scoreboard on responses.
// Latency: checks response cycle count against hit index / table size.
// Backpressure: exercises held responses, flush and reset aborts.
module tb_pmp_seq_checker;

    localparam int PLEN = 56;
    localparam int PMP_LEN = 54;
    localparam int NR = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  flush;
    logic                  req_valid;
    logic                  req_ready;
    logic [PLEN-1:0]       addr;
    logic [2:0]            access;
    logic [1:0]            priv;
    logic [NR*PMP_LEN-1:0] conf_addr;
    logic [NR*8-1:0]       conf;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_allow;
    logic                  rsp_hit;
    logic [3:0]            rsp_idx;

    pmp_seq_checker #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .addr_i      (addr),
        .access_i    (access),
        .priv_lvl_i  (priv),
        .conf_addr_i (conf_addr),
        .conf_i      (conf),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_allow_o (rsp_allow),
        .rsp_hit_o   (rsp_hit),
        .rsp_idx_o   (rsp_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        int              cfg;
        logic [PLEN-1:0] addr;
        logic [2:0]      acc;
        logic [1:0]      priv;
        logic            hit;
        logic [3:0]      idx;
        logic            allow;
        int              lat;
    } vec_t;

    typedef struct {
        string      name;
        logic       hit;
        logic [3:0] idx;
        logic       allow;
        int         lat;
        int         acc_cyc;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    vec_t vecs[$];
    vec_t pend;
    bit   pend_push = 1'b0;
    bit   prev_vld = 1'b0;

    localparam logic [1:0] PU = 2'b00, PS = 2'b01, PM = 2'b11;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input int c, input logic [PLEN-1:0] a,
                                input logic [2:0] ac, input logic [1:0] p, input logic h,
                                input logic [3:0] i, input logic al, input int l);
        vec_t v;
        v.name = n; v.cfg = c; v.addr = a; v.acc = ac; v.priv = p;
        v.hit = h; v.idx = i; v.allow = al; v.lat = l;
        return v;
    endfunction

    task automatic set_entry(input int i, input logic [PMP_LEN-1:0] a, input logic [7:0] c);
        conf_addr[i*PMP_LEN +: PMP_LEN] = a;
        conf[i*8 +: 8] = c;
    endtask

    // cfg byte = L<<7 | A<<3 | X<<2 | W<<1 | R
    task automatic set_cfg(input int id);
        conf_addr = '0;
        conf = '0;
        case (id)
            0: set_entry(0, 54'h400, 8'h09);
            1: set_entry(3, 54'h2000_01FF, 8'h1F);
            3: set_entry(1, 54'h40, 8'h91);
            4: set_entry(1, 54'h40, 8'h11);
            5: set_entry(0, 54'h80, 8'h12);
            6: begin
                set_entry(2, 54'hC0, 8'h11);
                set_entry(5, {PMP_LEN{1'b1}}, 8'h1F);
            end
            7: begin
                set_entry(14, 54'h100, 8'h00);
                set_entry(15, 54'h200, 8'h09);
            end
            default: ;
        endcase
    endtask

    // Scoreboard: push expectation at acceptance, pop and compare on each response rise
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (req_valid && req_ready && pend_push) begin
                e.name = pend.name; e.hit = pend.hit; e.idx = pend.idx;
                e.allow = pend.allow; e.lat = pend.lat; e.acc_cyc = cyc;
                sb.push_back(e);
            end
            if (rsp_valid && !prev_vld) begin
                if (sb.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, expected 0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_hit"}, rsp_hit, e.hit);
                    chk({e.name, "_idx"}, rsp_idx, e.idx);
                    chk({e.name, "_allow"}, rsp_allow, e.allow);
                    chk({e.name, "_lat"}, cyc - e.acc_cyc, e.lat);
                end
            end
        end
        prev_vld = rsp_valid;
    end

    // Caller sits just after a rising edge; returns just after the accepting edge
    task automatic send(input vec_t v, input bit push);
        int  n;
        bit  ok;
        pend = v; pend_push = push;
        addr = v.addr; access = v.acc; priv = v.priv; req_valid = 1'b1;
        n = 0; ok = 1'b0;
        while (n < 20 && !ok) begin
            @(negedge clk);
            ok = req_ready;
            n++;
        end
        if (!ok) begin
            errors++; checks++;
            $display("FAIL %s_accept: got req_ready_o=0 for 20 cycles, expected 1", v.name);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got no response in 60 cycles, expected one", nm);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic count_quiet(input string nm, input int ncyc);
        int seen;
        seen = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk(nm, seen, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        addr = '0; access = '0; priv = '0;
        set_cfg(2);
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_allow", rsp_allow, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_idx", rsp_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        //                name           cfg addr            acc   priv hit idx allow lat
        vecs.push_back(mk("tor_rd",      0, 56'h800,         3'b001, PU, 1, 0,  1, 2));
        vecs.push_back(mk("tor_wr",      0, 56'h800,         3'b010, PU, 1, 0,  0, 2));
        vecs.push_back(mk("tor_top",     0, 56'hFFC,         3'b001, PU, 1, 0,  1, 2));
        vecs.push_back(mk("tor_above",   0, 56'h1000,        3'b001, PU, 0, 0,  0, 17));
        vecs.push_back(mk("napot_hi",    1, 56'h8000_0FFC,   3'b100, PS, 1, 3,  1, 5));
        vecs.push_back(mk("napot_out",   1, 56'h8000_1000,   3'b100, PS, 0, 0,  0, 17));
        vecs.push_back(mk("napot_base",  1, 56'h8000_0000,   3'b100, PS, 1, 3,  1, 5));
        vecs.push_back(mk("napot_below", 1, 56'h7FFF_FFFC,   3'b100, PS, 0, 0,  0, 17));
        vecs.push_back(mk("off_m",       2, 56'h1234,        3'b001, PM, 0, 0,  1, 17));
        vecs.push_back(mk("off_u",       2, 56'h1234,        3'b001, PU, 0, 0,  0, 17));
        vecs.push_back(mk("na4_lock_x",  3, 56'h100,         3'b100, PM, 1, 1,  0, 3));
        vecs.push_back(mk("na4_lock_r",  3, 56'h100,         3'b001, PM, 1, 1,  1, 3));
        vecs.push_back(mk("na4_miss_m",  3, 56'h104,         3'b100, PM, 0, 0,  1, 17));
        vecs.push_back(mk("na4_unlock",  4, 56'h100,         3'b100, PM, 1, 1,  1, 3));
        vecs.push_back(mk("resv_wr",     5, 56'h200,         3'b010, PU, 1, 0,  0, 2));
        vecs.push_back(mk("resv_rw",     5, 56'h200,         3'b011, PU, 1, 0,  0, 2));
        vecs.push_back(mk("zero_acc",    5, 56'h200,         3'b000, PU, 1, 0,  1, 2));
        vecs.push_back(mk("prio_first",  6, 56'h300,         3'b010, PU, 1, 2,  0, 4));
        vecs.push_back(mk("prio_napot",  6, 56'h400,         3'b010, PU, 1, 5,  1, 7));
        vecs.push_back(mk("last_ent",    7, 56'h400,         3'b001, PU, 1, 15, 1, 17));
        vecs.push_back(mk("last_below",  7, 56'h3FC,         3'b001, PU, 0, 0,  0, 17));

        for (int i = 0; i < vecs.size(); i++) begin
            set_cfg(vecs[i].cfg);
            send(vecs[i], 1'b1);
            wait_rsp(vecs[i].name);
        end

        // Backpressure: response held for 5 cycles, then handshake and immediate new request
        set_cfg(0);
        rsp_ready = 1'b0;
        send(vecs[0], 1'b1);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", rsp_valid, 1);
            chk("bp_hit_hold", rsp_hit, 1);
            chk("bp_idx_hold", rsp_idx, 0);
            chk("bp_allow_hold", rsp_allow, 1);
            chk("bp_req_ready_low", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        pend = vecs[1]; pend_push = 1'b1;
        addr = vecs[1].addr; access = vecs[1].acc; priv = vecs[1].priv; req_valid = 1'b1;
        @(negedge clk);
        chk("bp_next_ready", req_ready, 1);
        chk("bp_valid_dropped", rsp_valid, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp("bp_next");

        // Flush in cycle 4 of a no-hit scan
        set_cfg(2);
        send(vecs[9], 1'b0);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_scan_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_ready", req_ready, 1);
        chk("flush_idle_valid", rsp_valid, 0);
        count_quiet("flush_no_rsp", 25);

        // Flush while idle blocks acceptance
        pend = vecs[8]; pend_push = 1'b0;
        addr = vecs[8].addr; access = vecs[8].acc; priv = vecs[8].priv;
        req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_block", req_ready, 0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_not_taken", req_ready, 1);
        count_quiet("flush_idle_no_rsp", 25);

        // Asynchronous reset mid-scan after a response left non-zero outputs
        set_cfg(6);
        send(vecs[18], 1'b1);
        wait_rsp("pre_rst");
        send(vecs[18], 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 1);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_rsp_allow", rsp_allow, 0);
        chk("arst_rsp_hit", rsp_hit, 0);
        chk("arst_rsp_idx", rsp_idx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_quiet("arst_no_rsp", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
